// File: rtl/sc_output_decoder.sv
// Counts ones per stochastic output stream over L valid samples, then argmax-scans N2 classes (done N2 edges after last sample).
// No backpressure: din is taken whenever din_valid is high in ACCUM and dropped otherwise.
module sc_output_decoder #(
    parameter int N2 = 10,
    parameter int L  = 256,
    localparam int CW = $clog2(L + 1),
    localparam int IW = (N2 > 1) ? $clog2(N2) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          din_valid,
    input  logic [N2-1:0] din,
    input  logic [IW-1:0] rd_sel,
    output logic [CW-1:0] rd_count,
    output logic          busy,
    output logic          done,
    output logic          result_valid,
    output logic [IW-1:0] class_idx,
    output logic [CW-1:0] max_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] counts [N2];
    logic [CW-1:0] sample_cnt;
    logic [IW-1:0] scan_idx;
    logic          last_sample;
    logic          last_scan;

    assign last_sample = din_valid && (sample_cnt == CW'(L - 1));
    assign last_scan   = (scan_idx == IW'(N2 - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)       state_nxt = ACCUM;
            ACCUM:      if (last_sample) state_nxt = SCAN;
            SCAN:       if (last_scan)   state_nxt = DONE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N2; i++) counts[i] <= '0;
            sample_cnt   <= '0;
            scan_idx     <= '0;
            class_idx    <= '0;
            max_count    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= (state_nxt == ACCUM) || (state_nxt == SCAN);
            done         <= (state_nxt == DONE) && (state != DONE);
            result_valid <= (state_nxt == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < N2; i++) counts[i] <= '0;
                        sample_cnt <= '0;
                        scan_idx   <= '0;
                        class_idx  <= '0;
                        max_count  <= '0;
                    end
                end
                ACCUM: begin
                    if (din_valid) begin
                        for (int i = 0; i < N2; i++) counts[i] <= counts[i] + CW'(din[i]);
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    // First class always loads; later ones only on strictly greater, so ties keep the lowest index.
                    if ((scan_idx == '0) || (counts[scan_idx] > max_count)) begin
                        max_count <= counts[scan_idx];
                        class_idx <= scan_idx;
                    end
                    scan_idx <= last_scan ? '0 : scan_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_count = '0;
        if (int'(rd_sel) < N2) rd_count = counts[rd_sel];
    end

endmodule

// File: tb/tb_sc_output_decoder.sv
// Bench for sc_output_decoder: directed and random windows checked against a counting/argmax model.
module tb_sc_output_decoder;
    localparam int N2 = 10;
    localparam int L  = 16;
    localparam int CW = $clog2(L + 1);
    localparam int IW = $clog2(N2);

    logic          clk = 1'b0;
    logic          reset, start, din_valid;
    logic [N2-1:0] din;
    logic [IW-1:0] rd_sel;
    logic [CW-1:0] rd_count, max_count;
    logic          busy, done, result_valid;
    logic [IW-1:0] class_idx;

    int total = 0;
    int bad   = 0;
    logic [N2-1:0] win_q[$];
    int exp_cnt[16];
    int exp_idx, exp_max;
    int obs_cnt[16];
    int lat, done_pulses, accum_cycles;

    sc_output_decoder #(.N2(N2), .L(L)) dut (
        .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
        .rd_sel(rd_sel), .rd_count(rd_count), .busy(busy), .done(done),
        .result_valid(result_valid), .class_idx(class_idx), .max_count(max_count)
    );

    always #5 clk = ~clk;

    // Reference: per-class popcount over the window, winner is the first class holding the maximum.
    task automatic build_model();
        for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
        foreach (win_q[s]) for (int i = 0; i < N2; i++) exp_cnt[i] += int'(win_q[s][i]);
        exp_max = -1;
        exp_idx = 0;
        for (int i = 0; i < N2; i++) if (exp_cnt[i] > exp_max) begin exp_max = exp_cnt[i]; exp_idx = i; end
    endtask

    task automatic read_counts();
        for (int i = 0; i < 16; i++) begin
            rd_sel = IW'(i);
            #1;
            obs_cnt[i] = int'(rd_count);
        end
    endtask

    // gap_mode: 0 none, 1 invalid on every other cycle (first one invalid), 2 random gaps.
    task automatic drive_window(input int gap_mode, input int mid_start_at);
        int k = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; din_valid = 1'b1; din = '1;
        @(negedge clk);
        start = 1'b0;
        while (k < win_q.size() && cyc < 1000) begin
            start = (k == mid_start_at);
            if ((gap_mode == 1 && cyc % 2 == 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                din_valid = 1'b0; din = '1;
            end else begin
                din_valid = 1'b1; din = win_q[k]; k++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; din_valid = 1'b0; din = '0;
        accum_cycles = cyc;
        lat = -1; done_pulses = 0;
        for (int e = 1; e <= N2 + 4; e++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (lat < 0) lat = e;
                done_pulses++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0 || class_idx !== '0 || max_count !== '0) begin
            bad++; $display("FAIL reset_outputs: busy=%b done=%b rv=%b idx=%0d max=%0d want all 0", busy, done, result_valid, class_idx, max_count);
        end
        read_counts();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_cnt[i] !== 0) begin bad++; $display("FAIL reset_count[%0d]: got %0d want 0", i, obs_cnt[i]); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_class();
        win_q = {};
        repeat (L) win_q.push_back(10'b0000001000);
        build_model();
        drive_window(0, -1);
        total++;
        if (lat !== N2) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, N2); end
        total++;
        if (done_pulses !== 1) begin bad++; $display("FAIL single_done_pulses: got %0d want 1", done_pulses); end
        total++;
        if (class_idx !== IW'(exp_idx) || max_count !== CW'(exp_max) || result_valid !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_result: idx=%0d max=%0d rv=%b busy=%b want idx=%0d max=%0d rv=1 busy=0",
                            class_idx, max_count, result_valid, busy, exp_idx, exp_max);
        end
        read_counts();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_cnt[i] !== exp_cnt[i]) begin bad++; $display("FAIL single_count[%0d]: got %0d want %0d", i, obs_cnt[i], exp_cnt[i]); end
        end
    endtask

    task automatic test_tie();
        logic [N2-1:0] p;
        win_q = {};
        for (int s = 0; s < L; s++) begin
            p = '0;
            p[2] = (s < 12); p[7] = (s >= 4); p[5] = (s < 11); p[0] = (s < 3); p[9] = s[0];
            win_q.push_back(p);
        end
        build_model();
        drive_window(0, -1);
        total++;
        if (class_idx !== IW'(exp_idx) || max_count !== CW'(exp_max) || lat !== N2) begin
            bad++; $display("FAIL tie_result: idx=%0d max=%0d lat=%0d want idx=%0d max=%0d lat=%0d",
                            class_idx, max_count, lat, exp_idx, exp_max, N2);
        end
    endtask

    task automatic test_gapped();
        win_q = {};
        repeat (L) win_q.push_back('1);
        build_model();
        drive_window(1, -1);
        total++;
        if (lat !== N2 || done_pulses !== 1) begin
            bad++; $display("FAIL gapped_done: lat=%0d pulses=%0d after %0d cycles want lat=%0d pulses=1", lat, done_pulses, accum_cycles, N2);
        end
        total++;
        if (class_idx !== IW'(exp_idx) || max_count !== CW'(exp_max)) begin
            bad++; $display("FAIL gapped_result: idx=%0d max=%0d want idx=%0d max=%0d", class_idx, max_count, exp_idx, exp_max);
        end
        read_counts();
        for (int i = 0; i < N2; i++) begin
            total++;
            if (obs_cnt[i] !== exp_cnt[i]) begin bad++; $display("FAIL gapped_count[%0d]: got %0d want %0d", i, obs_cnt[i], exp_cnt[i]); end
        end
    endtask

    task automatic test_all_zero();
        win_q = {};
        repeat (L) win_q.push_back('0);
        build_model();
        drive_window(0, -1);
        repeat (3) @(negedge clk);
        total++;
        if (class_idx !== IW'(exp_idx) || max_count !== CW'(exp_max) || result_valid !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL zero_result: idx=%0d max=%0d rv=%b done=%b want idx=%0d max=%0d rv=1 done=0",
                            class_idx, max_count, result_valid, done, exp_idx, exp_max);
        end
    endtask

    task automatic test_reset_mid_accum();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            din_valid = 1'b1; din = '1;
            if (s == 8) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0; din_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_state: busy=%b done=%b rv=%b want 0 0 0", busy, done, result_valid);
        end
        read_counts();
        for (int i = 0; i < N2; i++) begin
            total++;
            if (obs_cnt[i] !== 0) begin bad++; $display("FAIL midreset_count[%0d]: got %0d want 0", i, obs_cnt[i]); end
        end
        for (int c = 0; c < L + N2 + 4; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d busy/done cycles want 0", pulses); end
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            win_q = {};
            repeat (L) win_q.push_back(N2'($urandom));
            build_model();
            drive_window(2, -1);
            total++;
            if (class_idx !== IW'(exp_idx) || max_count !== CW'(exp_max) || lat !== N2 || done_pulses !== 1) begin
                bad++; $display("FAIL random%0d_result: idx=%0d max=%0d lat=%0d pulses=%0d want idx=%0d max=%0d lat=%0d pulses=1",
                                r, class_idx, max_count, lat, done_pulses, exp_idx, exp_max, N2);
            end
            read_counts();
            for (int i = 0; i < N2; i++) begin
                total++;
                if (obs_cnt[i] !== exp_cnt[i]) begin bad++; $display("FAIL random%0d_count[%0d]: got %0d want %0d", r, i, obs_cnt[i], exp_cnt[i]); end
            end
        end
    endtask

    task automatic test_start_ignored_and_restart();
        win_q = {};
        repeat (L) win_q.push_back(N2'($urandom));
        build_model();
        drive_window(0, 5);
        total++;
        if (class_idx !== IW'(exp_idx) || max_count !== CW'(exp_max) || lat !== N2) begin
            bad++; $display("FAIL midstart_result: idx=%0d max=%0d lat=%0d want idx=%0d max=%0d lat=%0d",
                            class_idx, max_count, lat, exp_idx, exp_max, N2);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL restart_flags: rv=%b busy=%b done=%b want rv=0 busy=1 done=0", result_valid, busy, done);
        end
        read_counts();
        for (int i = 0; i < N2; i++) begin
            total++;
            if (obs_cnt[i] !== 0) begin bad++; $display("FAIL restart_count[%0d]: got %0d want 0", i, obs_cnt[i]); end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0; rd_sel = '0;
        test_reset();
        test_single_class();
        test_tie();
        test_gapped();
        test_all_zero();
        test_reset_mid_accum();
        test_random(4);
        test_start_ignored_and_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
